regheap_result_drain: RTL and testbench
=======================================

// Module: regheap_result_drain
// PURPOSE
//  Read side of the 64x16b self-add register heap: captures a 1024-bit accumulated result
//  when the heap flags it valid and streams it out as 64-bit beats over a valid/ready link.
//  Sits between the heap's reg_data_w/reg_data_v_w outputs and a narrow downstream consumer
//  (host DMA or writeback FIFO), so one result vector drains while the next accumulates.
// PARAMETERS
//  IN_W     1024  captured result width (64 lanes x 16b)
//  OUT_W    64    output beat width (4 lanes per beat)
//  BEATS    16    IN_W/OUT_W; elaboration error if IN_W % OUT_W != 0
// PORTS
//  clk          in   1      single clock, all logic rising-edge
//  rst          in   1      asynchronous, active-low reset
//  usr_rst      in   1      synchronous clear: abort transfer, drop buffer, clear flags
//  reg_data_v   in   1      1-cycle strobe: reg_data holds a new result
//  reg_data     in   IN_W   result vector, lane k = bits [16k+15:16k]
//  need_data    out  1      1 = block can take a capture this cycle
//  out_v        out  1      out_data valid
//  out_rdy      in   1      downstream accepts beat when out_v & out_rdy
//  out_data     out  OUT_W  current beat
//  out_idx      out  4      beat index 0..BEATS-1 of current beat
//  out_last     out  1      out_v & (out_idx == BEATS-1)
//  overflow     out  1      sticky: a strobe arrived while need_data was 0
// BEHAVIOUR
//  - Reset (rst low, async): state IDLE, out_v=0, out_idx=0, out_last=0, out_data=0,
//    overflow=0, need_data=1; buffer contents don't-care. usr_rst high has the same effect
//    at the next edge and takes priority over all other inputs that cycle.
//  - States: IDLE (buffer empty) and SEND (buffer full, beats outstanding).
//  - IDLE: need_data=1. reg_data_v=1 -> latch reg_data into IN_W buffer, out_idx=0, go SEND.
//    Latency: strobe on edge N, out_v=1 with beat 0 visible from edge N+1.
//  - SEND: out_v=1; out_data = buffer[OUT_W*out_idx +: OUT_W] (low lanes first).
//    out_v & out_rdy & !out_last -> out_idx+1. out_v & !out_rdy -> hold out_data/out_idx
//    stable (no beat may change or drop while stalled).
//  - Final beat: out_last=1. need_data = out_rdy in SEND only on this beat (0 otherwise).
//    Handshake on last beat with no strobe -> IDLE, out_v=0.
//    Handshake on last beat with simultaneous reg_data_v -> latch new vector, out_idx wraps
//    to 0, stay SEND; out_v stays 1 with no bubble (back-to-back vectors, 16 beats each).
//  - Strobe while need_data=0: vector discarded, buffer/transfer unaffected, overflow<=1
//    until rst or usr_rst.
//  - out_idx is 4 bits for BEATS=16; width generalises to clog2(BEATS).
//  - No arithmetic on data: lanes pass bit-exact, including sign bits of 16b lanes.
//  - rst asserted mid-transfer: out_v drops immediately (async); remaining beats are lost.
//  - Throughput: 1 beat/cycle with out_rdy held 1; 16 cycles per vector.
// TESTING
//  1 rst low then high, no strobe -> out_v=0, need_data=1, overflow=0, out_idx=0.
//  2 strobe lane k = 16'(k+1), out_rdy=1 -> beats 0..15 on 16 consecutive cycles from N+1;
//    beat0 = 64'h0004_0003_0002_0001, beat15 = 64'h0040_003F_003E_003D, out_last only on 15.
//  3 same vector, out_rdy toggled 1,0,0,1,... -> data/idx stable during stalls, all 16 beats
//    delivered in order, none duplicated.
//  4 strobe A, strobe B on cycle of beat-15 handshake -> A beats 0..15 then B beat 0 next
//    cycle, no out_v gap; overflow stays 0.
//  5 strobe B during A beat 5 -> B dropped, overflow=1, A completes intact; usr_rst -> overflow=0,
//    out_v=0 next edge.
//  6 rst low at beat 7 of a transfer -> out_v=0 asynchronously; after release, idle with need_data=1.

Source files
------------

// File: rtl/regheap_result_drain.sv
// Read side of the self-add register heap: captures one accumulated result vector and
// drains it as OUT_W-bit beats over a valid/ready link, low lanes first.
module regheap_result_drain #(
  parameter int IN_W  = 1024,
  parameter int OUT_W = 64,
  parameter int BEATS = IN_W / OUT_W,
  parameter int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             usr_rst,
  input  logic             reg_data_v,
  input  logic [IN_W-1:0]  reg_data,
  output logic             need_data,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             overflow
);

  if ((IN_W % OUT_W) != 0 || (BEATS * OUT_W) != IN_W) begin : g_bad_width
    $error("regheap_result_drain: IN_W must be BEATS whole multiples of OUT_W");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [IN_W-1:0]  buf_q, buf_d;

  logic at_last;
  logic capture;
  logic advance;

  assign at_last   = (state_q == SEND) && (idx_q == LAST_IDX);
  // A new vector is only welcome while idle, or on the very cycle the last beat leaves.
  assign need_data = (state_q == IDLE) || (at_last && out_rdy);
  assign capture   = reg_data_v && need_data;
  assign advance   = (state_q == SEND) && out_rdy && !at_last;

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (reg_data_v && !need_data) ovf_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (reg_data_v) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (out_rdy) begin
          if (at_last) begin
            idx_d = '0;
            if (!reg_data_v) state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
    if (usr_rst) begin
      state_d = IDLE;
      idx_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // The buffer shifts right one beat per handshake, so the current beat is always its low slice.
  always_comb begin
    buf_d = buf_q;
    if (capture)      buf_d = reg_data;
    else if (advance) buf_d = buf_q >> OUT_W;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the data buffer is deliberately not reset; its contents are only observed in SEND.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_v    = (state_q == SEND);
  assign out_data = out_v ? buf_q[OUT_W-1:0] : '0;
  assign out_idx  = idx_q;
  assign out_last = at_last;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_regheap_result_drain.sv
// Directed bench for regheap_result_drain: a vector table for streaming and back-to-back
// transfers, plus hand-written stall, overflow, user-reset and async-reset sequences.
module tb_regheap_result_drain;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 64;
  localparam int BEATS = 16;

  logic              clk;
  logic              rst;
  logic              usr_rst;
  logic              reg_data_v;
  logic [IN_W-1:0]   reg_data;
  logic              need_data;
  logic              out_v;
  logic              out_rdy;
  logic [OUT_W-1:0]  out_data;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  regheap_result_drain #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .usr_rst    (usr_rst),
    .reg_data_v (reg_data_v),
    .reg_data   (reg_data),
    .need_data  (need_data),
    .out_v      (out_v),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          strobe;
    int          vid;
    bit          rdy;
    bit          exp_v;
    int          exp_idx;
    bit          exp_last;
    bit          exp_need;
    logic [63:0] exp_data;
  } row_t;

  row_t tbl[$];

  // Vector 0: lane k = k+1. Vector 1: sign bits set, varied low bits. Vector 2: filler.
  function automatic logic [15:0] lane_val(int vid, int k);
    case (vid)
      0:       return 16'(k + 1);
      1:       return 16'h8000 ^ 16'(k * 257);
      default: return 16'hDEAD ^ 16'(k);
    endcase
  endfunction

  function automatic logic [IN_W-1:0] make_vec(int vid);
    logic [IN_W-1:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) v[16*k +: 16] = lane_val(vid, k);
    return v;
  endfunction

  function automatic logic [63:0] beat_exp(int vid, int b);
    logic [63:0] d;
    d = {lane_val(vid, 4*b+3), lane_val(vid, 4*b+2), lane_val(vid, 4*b+1), lane_val(vid, 4*b)};
    if (vid == 0 && b == 0)  d = 64'h0004_0003_0002_0001;
    if (vid == 0 && b == 15) d = 64'h0040_003F_003E_003D;
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit strobe, input int vid, input bit rdy, input bit ur);
    reg_data_v = strobe;
    reg_data   = make_vec(strobe ? vid : 2);
    out_rdy    = rdy;
    usr_rst    = ur;
  endtask

  task automatic add_row(input bit strobe, input int vid, input bit rdy, input bit ev,
                         input int eidx, input bit elast, input bit eneed, input logic [63:0] ed);
    row_t r;
    r.strobe = strobe; r.vid = vid; r.rdy = rdy; r.exp_v = ev; r.exp_idx = eidx;
    r.exp_last = elast; r.exp_need = eneed; r.exp_data = ed;
    tbl.push_back(r);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_v"},     64'(out_v),     64'd0);
    check({tag, " need_data"}, 64'(need_data), 64'd1);
    check({tag, " out_idx"},   64'(out_idx),   64'd0);
    check({tag, " out_last"},  64'(out_last),  64'd0);
    check({tag, " out_data"},  out_data,       64'd0);
  endtask

  initial begin
    int got;
    bit done;

    rst = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);

    // 1: reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("reset");
    check("reset overflow", 64'(overflow), 64'd0);

    // 2: single vector, out_rdy held high. 4: A then B strobed on A's beat-15 handshake.
    add_row(1, 0, 1, 0, 0, 0, 1, 64'd0);
    for (int b = 0; b < BEATS; b++) add_row(0, 0, 1, 1, b, b == 15, b == 15, beat_exp(0, b));
    add_row(0, 0, 1, 0, 0, 0, 1, 64'd0);
    add_row(1, 0, 1, 0, 0, 0, 1, 64'd0);
    for (int b = 0; b < BEATS; b++) add_row(b == 15, 1, 1, 1, b, b == 15, b == 15, beat_exp(0, b));
    for (int b = 0; b < BEATS; b++) add_row(0, 1, 1, 1, b, b == 15, b == 15, beat_exp(1, b));
    add_row(0, 0, 1, 0, 0, 0, 1, 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].strobe, tbl[i].vid, tbl[i].rdy, 1'b0);
      #1;
      check($sformatf("row%0d out_v", i),     64'(out_v),     64'(tbl[i].exp_v));
      check($sformatf("row%0d need_data", i), 64'(need_data), 64'(tbl[i].exp_need));
      check($sformatf("row%0d overflow", i),  64'(overflow),  64'd0);
      if (tbl[i].exp_v) begin
        check($sformatf("row%0d out_idx", i),  64'(out_idx),  64'(tbl[i].exp_idx));
        check($sformatf("row%0d out_last", i), 64'(out_last), 64'(tbl[i].exp_last));
      end
      check($sformatf("row%0d out_data", i), out_data, tbl[i].exp_data);
    end

    // 3: stall pattern 1,0,0,1 -- beats must arrive in order, stable while stalled
    @(negedge clk);
    drive(1'b1, 0, 1'b0, 1'b0);
    got  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      drive(1'b0, 0, (c % 4 == 0) || (c % 4 == 3), 1'b0);
      #1;
      if (got == BEATS) begin
        check("stall final out_v", 64'(out_v), 64'd0);
        done = 1'b1;
      end else begin
        check($sformatf("stall c%0d out_v", c),    64'(out_v),    64'd1);
        check($sformatf("stall c%0d out_idx", c),  64'(out_idx),  64'(got));
        check($sformatf("stall c%0d out_data", c), out_data,      beat_exp(0, got));
        check($sformatf("stall c%0d out_last", c), 64'(out_last), 64'(got == 15));
        if (out_rdy) got++;
      end
    end
    check("stall completed within budget", 64'(done), 64'd1);

    // 5: strobe B during A beat 5 -> dropped, overflow sticky, A intact
    @(negedge clk);
    drive(1'b1, 0, 1'b1, 1'b0);
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      drive(b == 5, 1, 1'b1, 1'b0);
      #1;
      check($sformatf("ovf b%0d out_idx", b),  64'(out_idx),  64'(b));
      check($sformatf("ovf b%0d out_data", b), out_data,      beat_exp(0, b));
      check($sformatf("ovf b%0d overflow", b), 64'(overflow), 64'(b > 5));
    end
    @(negedge clk);
    drive(1'b1, 0, 1'b1, 1'b0);
    #1;
    check("ovf after A out_v", 64'(out_v), 64'd0);
    check("ovf sticky", 64'(overflow), 64'd1);
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, 0, 1'b1, 1'b0);
    end
    #1;
    check("usr_rst pre idx", 64'(out_idx), 64'd2);
    @(negedge clk);
    drive(1'b1, 1, 1'b1, 1'b1);
    #1;
    check("usr_rst pre out_v", 64'(out_v), 64'd1);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    #1;
    check_idle("usr_rst");
    check("usr_rst overflow", 64'(overflow), 64'd0);

    // 6: async reset at beat 7
    @(negedge clk);
    drive(1'b1, 0, 1'b1, 1'b0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      drive(1'b0, 0, b < 7, 1'b0);
    end
    #1;
    check("arst pre idx", 64'(out_idx), 64'd7);
    check("arst pre out_v", 64'(out_v), 64'd1);
    rst = 1'b0;
    #1;
    check_idle("arst async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle("arst released");
    check("arst overflow", 64'(overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
